// File: rtl/frame_mem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous frame memory: display first, cpu forced in after STARVE_MAX lost cycles.
// Latency: memory controls registered on the grant edge; read data returns to its owner RD_LAT+1 cycles after the transfer.
// Backpressure: requesters hold req/payload until gnt; one access per cycle, in-order return pipe, no stall on the return side.
module frame_mem_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 8
) (
    input  logic              clock_50,
    input  logic              reset,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_gnt,
    output logic              disp_rvalid,
    output logic [DATA_W-1:0] disp_rdata,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_q
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_we_q, mem_we_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    // Read-return tags: stage k holds the access issued k+1 cycles ago; owner 1 = cpu.
    logic [RD_LAT:0]   tag_vld_q, tag_vld_d;
    logic [RD_LAT:0]   tag_own_q, tag_own_d;
    logic [DATA_W-1:0] disp_rdata_q, disp_rdata_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;

    logic starved;
    logic rd_issue;

    assign starved = (starve_cnt_q == STARVE_LIM);

    // Grants are gated by reset so nothing can look accepted while the block is held in reset.
    assign disp_gnt = reset && disp_req && (!cpu_req || !starved);
    assign cpu_gnt  = reset && cpu_req && (!disp_req || starved);
    assign rd_issue = disp_gnt || (cpu_gnt && !cpu_we);

    assign disp_rvalid = tag_vld_q[RD_LAT] && !tag_own_q[RD_LAT];
    assign cpu_rvalid  = tag_vld_q[RD_LAT] && tag_own_q[RD_LAT];
    assign disp_rdata  = disp_rvalid ? mem_q : disp_rdata_q;
    assign cpu_rdata   = cpu_rvalid ? mem_q : cpu_rdata_q;

    assign mem_addr  = mem_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!cpu_req || cpu_gnt) begin
            starve_cnt_d = '0;
        end else if (disp_gnt && !starved) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end

        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (cpu_gnt) begin
            mem_addr_d  = cpu_addr;
            mem_we_d    = cpu_we;
            mem_wdata_d = cpu_wdata;
        end else if (disp_gnt) begin
            mem_addr_d = disp_addr;
        end

        tag_vld_d = {tag_vld_q[RD_LAT-1:0], rd_issue};
        tag_own_d = {tag_own_q[RD_LAT-1:0], cpu_gnt};

        disp_rdata_d = disp_rdata;
        cpu_rdata_d  = cpu_rdata;
    end

    always_ff @(posedge clock_50 or negedge reset) begin
        if (!reset) begin
            starve_cnt_q <= '0;
            mem_addr_q   <= '0;
            mem_we_q     <= 1'b0;
            mem_wdata_q  <= '0;
            tag_vld_q    <= '0;
            tag_own_q    <= '0;
            disp_rdata_q <= '0;
            cpu_rdata_q  <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            mem_addr_q   <= mem_addr_d;
            mem_we_q     <= mem_we_d;
            mem_wdata_q  <= mem_wdata_d;
            tag_vld_q    <= tag_vld_d;
            tag_own_q    <= tag_own_d;
            disp_rdata_q <= disp_rdata_d;
            cpu_rdata_q  <= cpu_rdata_d;
        end
    end

endmodule

// File: tb/tb_frame_mem_arbiter.sv
// Bench for frame_mem_arbiter: instance 0 (STARVE_MAX=4, RD_LAT=1) and instance 1 (STARVE_MAX=8, RD_LAT=2),
// each with its own memory model and read-return scoreboard.
module tb_frame_mem_arbiter;

    typedef struct {
        logic        owner;
        logic [31:0] data;
        int          due;
    } exp_t;

    logic        clk;
    logic        rst_n;
    int          cyc;
    int          checks;
    int          errors;

    logic [1:0]  dreq, dgnt, drv;
    logic [1:0]  creq, cwe, cgnt, crv;
    logic [1:0]  mwe;
    logic [15:0] daddr [2];
    logic [15:0] caddr [2];
    logic [15:0] maddr [2];
    logic [31:0] cwdata [2];
    logic [31:0] drdata [2];
    logic [31:0] crdata [2];
    logic [31:0] mwdata [2];
    logic [31:0] memq [2];

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : u
        localparam int LAT = (g == 0) ? 1 : 2;
        localparam int SM  = (g == 0) ? 4 : 8;

        frame_mem_arbiter #(
            .ADDR_W(16), .DATA_W(32), .RD_LAT(LAT), .STARVE_MAX(SM)
        ) dut (
            .clock_50   (clk),
            .reset      (rst_n),
            .disp_req   (dreq[g]),
            .disp_addr  (daddr[g]),
            .disp_gnt   (dgnt[g]),
            .disp_rvalid(drv[g]),
            .disp_rdata (drdata[g]),
            .cpu_req    (creq[g]),
            .cpu_we     (cwe[g]),
            .cpu_addr   (caddr[g]),
            .cpu_wdata  (cwdata[g]),
            .cpu_gnt    (cgnt[g]),
            .cpu_rvalid (crv[g]),
            .cpu_rdata  (crdata[g]),
            .mem_addr   (maddr[g]),
            .mem_we     (mwe[g]),
            .mem_wdata  (mwdata[g]),
            .mem_q      (memq[g])
        );

        // Memory model: unwritten word a reads as a+0x100; q appears LAT cycles after the address.
        bit          wr_vld [256];
        logic [31:0] wr_dat [256];
        logic [31:0] qpipe [LAT];

        always @(posedge clk) begin
            if (mwe[g]) begin
                wr_vld[maddr[g][7:0]] <= 1'b1;
                wr_dat[maddr[g][7:0]] <= mwdata[g];
            end
            qpipe[0] <= wr_vld[maddr[g][7:0]] ? wr_dat[maddr[g][7:0]] : 32'h100 + 32'(maddr[g][7:0]);
            for (int i = 1; i < LAT; i++) qpipe[i] <= qpipe[i-1];
        end
        assign memq[g] = qpipe[LAT-1];

        // Reference contents, updated at write acceptance.
        bit          rf_vld [256];
        logic [31:0] rf_dat [256];
        exp_t        sbq [$];
        logic [31:0] last_d, last_c;

        function automatic logic [31:0] ref_rd(input logic [15:0] a);
            return rf_vld[a[7:0]] ? rf_dat[a[7:0]] : 32'h100 + 32'(a[7:0]);
        endfunction

        always @(negedge clk) begin
            if (!rst_n) begin
                sbq.delete();
                last_d <= '0;
                last_c <= '0;
            end else begin
                chk("gnt_exclusive", {62'd0, dgnt[g], cgnt[g]} & {62'd0, dgnt[g] & cgnt[g], 1'b0}, 0);
                if (drv[g] || crv[g]) begin
                    if (sbq.size() == 0) begin
                        chk("rv_spurious", {62'd0, drv[g], crv[g]}, 0);
                    end else begin
                        chk("rv_port", {62'd0, drv[g], crv[g]}, sbq[0].owner ? 64'd1 : 64'd2);
                        chk("rv_cycle", 64'(cyc), 64'(sbq[0].due));
                        if (sbq[0].owner) begin
                            chk("cpu_rdata", crdata[g], sbq[0].data);
                            chk("disp_rdata_hold", drdata[g], last_d);
                            last_c <= sbq[0].data;
                        end else begin
                            chk("disp_rdata", drdata[g], sbq[0].data);
                            chk("cpu_rdata_hold", crdata[g], last_c);
                            last_d <= sbq[0].data;
                        end
                        void'(sbq.pop_front());
                    end
                end else if (sbq.size() != 0 && sbq[0].due <= cyc) begin
                    chk("rv_missing", 0, 1);
                    void'(sbq.pop_front());
                end
                if (dreq[g] && dgnt[g]) begin
                    sbq.push_back('{owner: 1'b0, data: ref_rd(daddr[g]), due: cyc + 1 + LAT});
                end else if (creq[g] && cgnt[g]) begin
                    if (cwe[g]) begin
                        rf_vld[caddr[g][7:0]] <= 1'b1;
                        rf_dat[caddr[g][7:0]] <= cwdata[g];
                    end else begin
                        sbq.push_back('{owner: 1'b1, data: ref_rd(caddr[g]), due: cyc + 1 + LAT});
                    end
                end
            end
        end
    end

    // Entered and left at 1 time unit after a rising edge; checks {disp_gnt, cpu_gnt} mid-cycle.
    task automatic cyc_step(input int n, input string tag, input logic [1:0] exp_g);
        @(negedge clk);
        chk(tag, {62'd0, dgnt[n], cgnt[n]}, {62'd0, exp_g});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        rst_n  = 1'b0;
        dreq = 2'b01; creq = 2'b01; cwe = 2'b00;
        for (int i = 0; i < 2; i++) begin
            daddr[i] = '0; caddr[i] = '0; cwdata[i] = '0;
        end

        // Reset with both requests high: everything quiet.
        repeat (2) @(negedge clk);
        chk("rst_disp_gnt", dgnt[0], 0);
        chk("rst_cpu_gnt", cgnt[0], 0);
        chk("rst_rvalid", {62'd0, drv[0], crv[0]}, 0);
        chk("rst_mem_we", mwe[0], 0);
        chk("rst_mem_addr", maddr[0], 0);
        chk("rst_mem_wdata", mwdata[0], 0);
        @(posedge clk); #1;
        rst_n = 1'b1; dreq = 2'b00; creq = 2'b00;
        idle(2);

        // Back-to-back display fetches 0..3.
        for (int k = 0; k < 4; k++) begin
            dreq[0] = 1'b1; daddr[0] = 16'(k);
            cyc_step(0, "t1_disp_gnt", 2'b10);
        end
        dreq[0] = 1'b0;
        idle(4);

        // cpu write then immediate read of the same word.
        creq[0] = 1'b1; cwe[0] = 1'b1; caddr[0] = 16'h0020; cwdata[0] = 32'hDEADBEEF;
        cyc_step(0, "t2_wr_gnt", 2'b01);
        cwe[0] = 1'b0;
        @(negedge clk);
        chk("t2_mem_we_hi", mwe[0], 1);
        chk("t2_mem_addr", maddr[0], 16'h0020);
        chk("t2_mem_wdata", mwdata[0], 32'hDEADBEEF);
        chk("t2_rd_gnt", cgnt[0], 1);
        @(posedge clk); #1;
        creq[0] = 1'b0;
        @(negedge clk);
        chk("t2_mem_we_lo", mwe[0], 0);
        @(posedge clk); #1;
        idle(4);

        // Both held: D,D,D,D,C repeating.
        dreq[0] = 1'b1; daddr[0] = 16'h0040;
        creq[0] = 1'b1; cwe[0] = 1'b0; caddr[0] = 16'h0080;
        for (int i = 0; i < 10; i++) cyc_step(0, "t3_pattern", (i % 5 == 4) ? 2'b01 : 2'b10);

        // cpu_req gap clears the starvation count.
        cyc_step(0, "t4_pre", 2'b10);
        cyc_step(0, "t4_pre", 2'b10);
        creq[0] = 1'b0;
        cyc_step(0, "t4_gap", 2'b10);
        creq[0] = 1'b1;
        for (int i = 0; i < 5; i++) cyc_step(0, "t4_after_gap", (i == 4) ? 2'b01 : 2'b10);
        dreq[0] = 1'b0; creq[0] = 1'b0;
        idle(4);

        // Reset while a cpu read is in flight.
        creq[0] = 1'b1; cwe[0] = 1'b0; caddr[0] = 16'h0030;
        cyc_step(0, "t5_rd_gnt", 2'b01);
        creq[0] = 1'b0; dreq[0] = 1'b1; rst_n = 1'b0;
        @(negedge clk);
        chk("t5_rst_gnt", {62'd0, dgnt[0], cgnt[0]}, 0);
        chk("t5_rst_rvalid", {62'd0, drv[0], crv[0]}, 0);
        chk("t5_rst_mem_addr", maddr[0], 0);
        @(posedge clk); #1;
        rst_n = 1'b1; dreq[0] = 1'b0;
        idle(4);
        creq[0] = 1'b1; caddr[0] = 16'h0031;
        cyc_step(0, "t5_post_gnt", 2'b01);
        creq[0] = 1'b0;
        idle(4);

        // RD_LAT=2 instance: alternating display and cpu reads.
        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 0) begin
                dreq[1] = 1'b1; creq[1] = 1'b0; daddr[1] = 16'h0050 + 16'(k);
                cyc_step(1, "t6_disp_gnt", 2'b10);
            end else begin
                dreq[1] = 1'b0; creq[1] = 1'b1; cwe[1] = 1'b0; caddr[1] = 16'h0060 + 16'(k);
                cyc_step(1, "t6_cpu_gnt", 2'b01);
            end
        end
        dreq[1] = 1'b0; creq[1] = 1'b0;
        idle(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
